// File: rtl/sm_ctrl.sv
// Control front-end for the sm up/down counter: button sync/debounce, IDLE/RUN/HALT sequencing, overflow tally.
// Latency: raw button edge reaches act DB_CYCLES+2 edges after the first sample; dir toggle lands the same edge.
// Backpressure: none; ovflw from sm halts counting (act drops) until the operator re-arms with a run press.
module sm_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int EVW       = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           btn_run_raw,
    input  logic           btn_dir_raw,
    input  logic           ovflw,
    output logic           act,
    output logic           up_dwn_n,
    output logic           halted,
    output logic [EVW-1:0] ovf_events
);

    localparam int             CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    // Bit 0 carries the run/pause button, bit 1 the direction button.
    localparam int BTN_RUN = 0;
    localparam int BTN_DIR = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    logic [1:0]    btn_raw;
    logic [1:0]    sync_q1;
    logic [1:0]    sync_q2;
    logic [1:0]    db;
    logic [1:0]    db_d;
    logic [CW-1:0] db_cnt [2];
    logic [1:0]    press;

    state_t        state_q;
    state_t        state_d;
    logic          ovflw_d;

    assign btn_raw = {btn_dir_raw, btn_run_raw};

    // Two-flop synchronisers bring the asynchronous buttons into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: level follows the synchronised input only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_d <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    db[i]     <= sync_q2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the rising edge of a debounced level is a press; releases are ignored.
    assign press = db & ~db_d;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: overflow in RUN beats a same-cycle run press; HALT only re-arms once ovflw has cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (press[BTN_RUN]) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ovflw) begin
                    state_d = ST_HALT;
                end else if (press[BTN_RUN]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (press[BTN_RUN] && !ovflw) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state flop, so reset drops act without waiting for a clock.
    assign act    = (state_q == ST_RUN);
    assign halted = (state_q == ST_HALT);

    // Direction flips on every dir press, regardless of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_dwn_n <= 1'b1;
        end else if (press[BTN_DIR]) begin
            up_dwn_n <= ~up_dwn_n;
        end
    end

    // Saturating count of ovflw rising edges that arrive while counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovflw_d    <= 1'b0;
            ovf_events <= '0;
        end else begin
            ovflw_d <= ovflw;
            if (ovflw && !ovflw_d && (state_q == ST_RUN) && !(&ovf_events)) begin
                ovf_events <= ovf_events + 1'b1;
            end
        end
    end

endmodule
